// File: rtl/fetch_stage_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the IF/ID register outputs.
// Signal suffixes are relative to the fetch stage, which uses the master modport.
interface fetch_stage_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;

  modport master (
    output imem_addr_o,
    input  imem_instr_i,
    output if_id_valid_o,
    output if_id_pc_o,
    output if_id_instr_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_instr_i,
    input  if_id_valid_o,
    input  if_id_pc_o,
    input  if_id_instr_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills the IF/ID register.
// Handles stall, flush, redirect and traps on misaligned or out-of-range fetch addresses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          redirect_valid_i,
  input  logic [31:0]   redirect_pc_i,
  fetch_stage_if.master bus,
  output logic          trap_o,
  output logic [31:0]   trap_pc_o,
  output logic [31:0]   fetch_count_o
);

  localparam logic [31:0] PcLimit = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {StBoot, StRun, StTrap} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_trap;
  logic [31:0] r_trap_pc;
  logic [31:0] r_count;

  logic        w_fault;

  assign w_fault = (r_pc[1:0] != 2'b00) || (r_pc > PcLimit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StBoot;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
      r_trap     <= 1'b0;
      r_trap_pc  <= 32'h0;
      r_count    <= 32'h0;
    end else begin
      unique case (r_state)
        StBoot: begin
          if (redirect_valid_i) r_pc <= redirect_pc_i;
          r_state <= StRun;
        end
        StRun: begin
          if (redirect_valid_i) begin
            r_pc    <= redirect_pc_i;
            r_valid <= 1'b0;
          end else if (flush_i) begin
            r_valid <= 1'b0;
          end else if (stall_i) begin
            r_valid <= r_valid;
          end else if (w_fault) begin
            r_state   <= StTrap;
            r_trap    <= 1'b1;
            r_trap_pc <= r_pc;
            r_valid   <= 1'b0;
          end else begin
            r_if_pc    <= r_pc;
            r_if_instr <= bus.imem_instr_i;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 32'd4;
            if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
          end
        end
        StTrap: begin
          // Fault is re-evaluated in RUN, so a bad target traps again one cycle later.
          if (redirect_valid_i) begin
            r_pc    <= redirect_pc_i;
            r_trap  <= 1'b0;
            r_state <= StRun;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

  assign bus.imem_addr_o   = r_pc;
  assign bus.if_id_valid_o = r_valid;
  assign bus.if_id_pc_o    = r_if_pc;
  assign bus.if_id_instr_o = r_if_instr;
  assign trap_o            = r_trap;
  assign trap_pc_o         = r_trap_pc;
  assign fetch_count_o     = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected deliveries, a negedge monitor
// pops and compares each new IF/ID delivery; control/trap state is checked directly.
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redir;
  logic [31:0] redir_pc;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] last_count;

  fetch_stage_if u_if ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(1024)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .stall_i         (stall),
    .flush_i         (flush),
    .redirect_valid_i(redir),
    .redirect_pc_i   (redir_pc),
    .bus             (u_if.master),
    .trap_o          (trap),
    .trap_pc_o       (trap_pc),
    .fetch_count_o   (count)
  );

  // Memory image: word at byte address a is C0DE_0000 ^ a; misaligned or out of range reads 0.
  always_comb begin
    if (u_if.imem_addr_o[1:0] != 2'b00 || u_if.imem_addr_o >= 32'd1024)
      u_if.imem_instr_i = 32'h0;
    else
      u_if.imem_instr_i = 32'hC0DE_0000 ^ u_if.imem_addr_o;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp);
    stall = s; flush = f; redir = r; redir_pc = rp;
  endtask

  // Monitor: a new delivery is a valid IF/ID with the delivery counter having moved.
  always @(negedge clk) begin
    if (rst_n && u_if.if_id_valid_o && count != last_count) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_delivery: got pc %h none expected", u_if.if_id_pc_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("deliv_pc", u_if.if_id_pc_o, e[63:32]);
        chk("deliv_instr", u_if.if_id_instr_o, e[31:0]);
      end
    end
    last_count = count;
  end

  initial begin
    last_count = 32'h0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_addr", u_if.imem_addr_o, 32'h0);
    chk("rst_valid", {31'h0, u_if.if_id_valid_o}, 32'h0);
    chk("rst_if_pc", u_if.if_id_pc_o, 32'h0);
    chk("rst_if_instr", u_if.if_id_instr_o, 32'h0);
    chk("rst_trap", {31'h0, trap}, 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);
    chk("rst_count", count, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    // BOOT cycle: no fetch.
    cyc();
    chk("boot_valid", {31'h0, u_if.if_id_valid_o}, 32'h0);
    chk("boot_addr", u_if.imem_addr_o, 32'h0);
    chk("boot_count", count, 32'h0);

    // Sequential fetch 0, 4 then stall with IF/ID at 4.
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    cyc();
    cyc();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_if_pc", u_if.if_id_pc_o, 32'h4);
      chk("stall_addr", u_if.imem_addr_o, 32'h8);
      chk("stall_count", count, 32'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    push_exp(32'h8, 32'hC0DE_0008);
    push_exp(32'hC, 32'hC0DE_000C);
    cyc();
    cyc();
    chk("seq_count", count, 32'd4);

    // Redirect wins over a simultaneous stall.
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    cyc();
    chk("redir_addr", u_if.imem_addr_o, 32'h40);
    chk("redir_bubble", {31'h0, u_if.if_id_valid_o}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    push_exp(32'h40, 32'hC0DE_0040);
    cyc();
    chk("redir_valid", {31'h0, u_if.if_id_valid_o}, 32'h1);

    // Flush drops IF/ID and holds pc.
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    chk("flush_valid", {31'h0, u_if.if_id_valid_o}, 32'h0);
    chk("flush_addr", u_if.imem_addr_o, 32'h44);

    // Misaligned redirect traps on the following RUN cycle.
    drive(1'b0, 1'b0, 1'b1, 32'h42);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    chk("mis_trap", {31'h0, trap}, 32'h1);
    chk("mis_trap_pc", trap_pc, 32'h42);
    chk("mis_valid", {31'h0, u_if.if_id_valid_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(i[0], ~i[0], 1'b0, 32'h0);
      cyc();
      chk("trap_hold_addr", u_if.imem_addr_o, 32'h42);
      chk("trap_hold", {31'h0, trap}, 32'h1);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h10);
    cyc();
    chk("trap_clear", {31'h0, trap}, 32'h0);
    chk("trap_redir_addr", u_if.imem_addr_o, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    push_exp(32'h10, 32'hC0DE_0010);
    cyc();
    chk("post_trap_count", count, 32'd6);

    // Out-of-range: 0x3FC is the last legal word, 0x400 traps.
    drive(1'b0, 1'b0, 1'b1, 32'h3F8);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    push_exp(32'h3F8, 32'hC0DE_03F8);
    push_exp(32'h3FC, 32'hC0DE_03FC);
    cyc();
    cyc();
    chk("oor_addr", u_if.imem_addr_o, 32'h400);
    cyc();
    chk("oor_trap", {31'h0, trap}, 32'h1);
    chk("oor_trap_pc", trap_pc, 32'h400);
    chk("oor_count", count, 32'd8);
    chk("oor_valid", {31'h0, u_if.if_id_valid_o}, 32'h0);
    chk("oor_if_pc_hold", u_if.if_id_pc_o, 32'h3FC);

    // Asynchronous reset between edges while trapped.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_trap", {31'h0, trap}, 32'h0);
    chk("async_valid", {31'h0, u_if.if_id_valid_o}, 32'h0);
    chk("async_addr", u_if.imem_addr_o, 32'h0);
    chk("async_count", count, 32'h0);
    chk("async_trap_pc", trap_pc, 32'h0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that owns the program counter (PC) and drives the byte address into the instruction memory. The instruction memory returns a 32-bit big-endian word combinationally, and returns 0 for a misaligned address. This stage captures the returned word, with its PC, into the IF/ID pipeline register feeding the decoder. It handles stall, flush, branch/jump redirect and fetch traps.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_BYTES, 1024, instruction memory size in bytes; fetch addresses must be < MEM_BYTES.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
stall_i  input  1  decoder cannot accept; hold PC and IF/ID.
flush_i  input  1  invalidate IF/ID contents.
redirect_valid_i  input  1  load a new PC.
redirect_pc_i  input  32  redirect target byte address.
imem_instr_i  input  32  word returned by instruction memory for imem_addr_o.
imem_addr_o  output  32  fetch byte address; equals current PC.
if_id_valid_o  output  1  IF/ID holds a valid instruction.
if_id_pc_o  output  32  PC of the IF/ID instruction.
if_id_instr_o  output  32  IF/ID instruction word.
trap_o  output  1  fetch trap active.
trap_pc_o  output  32  PC that caused the trap.
fetch_count_o  output  32  number of instructions delivered into IF/ID.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - pc=RESET_PC; state=BOOT.
  - if_id_valid_o=0, if_id_pc_o=0, if_id_instr_o=0.
  - trap_o=0, trap_pc_o=0, fetch_count_o=0.
- imem_addr_o = pc at all times, combinational from the register.
- States:
  - BOOT: one cycle, no fetch, if_id_valid_o stays 0; always goes to RUN on the next edge. A redirect in BOOT loads pc and still goes to RUN.
  - RUN: normal fetch.
  - TRAP: fetch halted.
- Fault condition: pc[1:0]!=0 OR pc > MEM_BYTES-4.
- Per-edge priority in RUN, highest first:
  1. redirect_valid_i:
     - pc <= redirect_pc_i.
     - if_id_valid_o <= 0; if_id_pc_o and if_id_instr_o hold.
     - stall_i and flush_i are ignored this cycle.
  2. flush_i: if_id_valid_o <= 0; pc holds. A flush with stall also holds pc.
  3. stall_i: pc, if_id_* and fetch_count_o all hold.
  4. Fault condition true:
     - Go to TRAP; trap_o <= 1; trap_pc_o <= pc.
     - if_id_valid_o <= 0; pc holds.
  5. Otherwise:
     - if_id_pc_o <= pc; if_id_instr_o <= imem_instr_i; if_id_valid_o <= 1.
     - pc <= pc+4, modulo 2^32.
     - fetch_count_o increments, saturating at 32'hFFFF_FFFF.
- TRAP:
  - if_id_valid_o held at 0; pc held; stall_i and flush_i have no effect.
  - redirect_valid_i: pc <= redirect_pc_i, trap_o <= 0, go to RUN. The fault check is re-applied on the next RUN cycle, so a bad target re-traps one cycle later.
- Latency: an instruction at PC p appears on if_id_* one edge after pc==p in an unstalled RUN cycle. Throughput is one instruction per cycle.
- Redirect bubble: exactly one cycle with if_id_valid_o=0 after a redirect.
- trap_pc_o holds its value until the next trap or reset.
- Reset asserted mid-stall or mid-trap returns every output to its reset value immediately, without waiting for a clock edge.

Test Plan:
- Sequential fetch: reset release, RESET_PC=0, memory words W0..W3 at 0,4,8,12. Expect:
  - cycle 1 BOOT with valid=0;
  - then if_id_pc_o=0,4,8,12 with matching instructions on consecutive cycles;
  - fetch_count_o=4.
- Stall: stall_i high for 3 cycles while if_id_pc_o=4. Expect if_id_pc_o=4, imem_addr_o=8 and fetch_count_o constant; after release, next if_id_pc_o=8.
- Redirect with simultaneous stall: redirect_pc_i=0x40 with stall_i=1. Expect next cycle imem_addr_o=0x40 and valid=0; the following cycle if_id_pc_o=0x40 with valid=1.
- Misaligned redirect: redirect_pc_i=0x42. Expect:
  - next cycle RUN detects the fault, then trap_o=1 and trap_pc_o=0x42, valid=0;
  - pc holds while stall/flush are toggled;
  - redirect to 0x10 clears trap_o and the next delivered if_id_pc_o=0x10.
- Out-of-range: sequential run reaching pc=0x3FC delivers that instruction, then pc=0x400 traps with trap_pc_o=0x400.
- Async reset mid-operation: assert rst_ni low between clock edges during TRAP. Expect trap_o=0, if_id_valid_o=0, imem_addr_o=RESET_PC and fetch_count_o=0 immediately.
